// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor on the free-running reference clock: pulses the PLL
// reset, waits for a stable lock with timeout/retry, and gates sys_rst/ready.
//
// state       | meaning
// ------------|------------------------------------------------------------
// PLL_RESET   | pll_rst held high for PLL_RST_CYCLES clocks
// WAIT_LOCK   | waiting for lock_s, timeout triggers a retry
// STABLE      | lock_s must stay high for LOCK_STABLE clocks
// RUN         | PLL-domain logic released, lock monitored
// FAILED      | retries exhausted, only reset leaves
module pll_lock_supervisor #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 125000,
  parameter int LOCK_STABLE    = 1024,
  parameter int MAX_RETRIES    = 4,
  localparam int RCW           = $clog2(MAX_RETRIES + 1)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           pll_lock,
  output logic           pll_rst,
  output logic           sys_rst,
  output logic           ready,
  output logic           fail,
  output logic [RCW-1:0] retry_count,
  output logic [7:0]     lock_loss_count
);

  localparam int TMAX_A = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
  localparam int TMAX   = (TMAX_A > PLL_RST_CYCLES) ? TMAX_A : PLL_RST_CYCLES;
  localparam int TW     = $clog2(TMAX + 1);

  localparam logic [TW-1:0]  T_RST_LAST     = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0]  T_TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0]  T_STABLE_LAST  = TW'(LOCK_STABLE - 1);
  localparam logic [RCW-1:0] RC_MAX         = RCW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLL_RESET = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAILED    = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [TW-1:0]    timer, timer_nxt;
  logic [RCW-1:0]   retry_nxt;
  logic [7:0]       loss_nxt;
  logic             pll_rst_d, sys_rst_d, ready_d, fail_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             lock_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= S_PLL_RESET;
      timer           <= '0;
      retry_count     <= '0;
      lock_loss_count <= '0;
      pll_rst         <= 1'b1;
      sys_rst         <= 1'b1;
      ready           <= 1'b0;
      fail            <= 1'b0;
    end else begin
      state           <= state_nxt;
      timer           <= timer_nxt;
      retry_count     <= retry_nxt;
      lock_loss_count <= loss_nxt;
      pll_rst         <= pll_rst_d;
      sys_rst         <= sys_rst_d;
      ready           <= ready_d;
      fail            <= fail_d;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer + 1'b1;
    retry_nxt = retry_count;
    loss_nxt  = lock_loss_count;
    case (state)
      S_PLL_RESET: begin
        if (timer == T_RST_LAST) state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // lock is checked first so a lock on the timeout clock wins
        if (lock_s) begin
          state_nxt = S_STABLE;
        end else if (timer == T_TIMEOUT_LAST) begin
          retry_nxt = retry_count + 1'b1;
          state_nxt = (retry_nxt == RC_MAX) ? S_FAILED : S_PLL_RESET;
        end
      end
      S_STABLE: begin
        if (!lock_s)                       state_nxt = S_WAIT_LOCK;
        else if (timer == T_STABLE_LAST)   state_nxt = S_RUN;
      end
      S_RUN: begin
        timer_nxt = timer;
        if (!lock_s) begin
          state_nxt = S_PLL_RESET;
          if (lock_loss_count != 8'hFF) loss_nxt = lock_loss_count + 1'b1;
        end
      end
      S_FAILED: begin
        timer_nxt = timer;
      end
      default: begin
        state_nxt = S_PLL_RESET;
      end
    endcase
    if (state_nxt != state) timer_nxt = '0;
    if (state_nxt == S_RUN && state != S_RUN) retry_nxt = '0;
  end

  // outputs are decoded from the next state so they switch on the transition edge
  always_comb begin
    pll_rst_d = (state_nxt == S_PLL_RESET);
    sys_rst_d = (state_nxt != S_RUN);
    ready_d   = (state_nxt == S_RUN);
    fail_d    = (state_nxt == S_FAILED);
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: stimulus queues expected output
// changes (with cycle stamps); monitors pop and compare as the DUT presents them.
module tb_pll_lock_supervisor;

  localparam int RCW = 2;

  logic           clock = 1'b0;
  logic           reset;
  logic           pll_lock;
  logic           pll_rst, sys_rst, ready, fail;
  logic [RCW-1:0] retry_count;
  logic [7:0]     lock_loss_count;

  typedef struct {
    int             c;
    logic           pr, sr, rd, fl;
    logic [RCW-1:0] rc;
    logic [7:0]     llc;
  } exp_t;

  exp_t chg_q[$];
  exp_t poll_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  pll_lock_supervisor #(
    .SYNC_STAGES(2), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(20),
    .LOCK_STABLE(8), .MAX_RETRIES(2)
  ) dut (
    .clock(clock), .reset(reset), .pll_lock(pll_lock),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .fail(fail),
    .retry_count(retry_count), .lock_loss_count(lock_loss_count)
  );

  initial forever #4 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic compare(input string tag, input exp_t e);
    n_checks++;
    if (cyc != e.c || pll_rst !== e.pr || sys_rst !== e.sr || ready !== e.rd ||
        fail !== e.fl || retry_count !== e.rc || lock_loss_count !== e.llc) begin
      n_fail++;
      $display("FAIL %s: got cyc=%0d pll_rst=%b sys_rst=%b ready=%b fail=%b retry=%0d loss=%0d; required cyc=%0d pll_rst=%b sys_rst=%b ready=%b fail=%b retry=%0d loss=%0d",
               tag, cyc, pll_rst, sys_rst, ready, fail, retry_count, lock_loss_count,
               e.c, e.pr, e.sr, e.rd, e.fl, e.rc, e.llc);
    end
  endtask

  task automatic mk(output exp_t e, input int c, input logic pr, input logic sr,
                    input logic rd, input logic fl, input int rc, input int llc);
    e.c = c; e.pr = pr; e.sr = sr; e.rd = rd; e.fl = fl;
    e.rc = rc[RCW-1:0]; e.llc = llc[7:0];
  endtask

  task automatic exp_chg(input int c, input logic pr, input logic sr, input logic rd,
                         input logic fl, input int rc, input int llc);
    exp_t e;
    mk(e, c, pr, sr, rd, fl, rc, llc);
    chg_q.push_back(e);
  endtask

  task automatic exp_poll(input int c, input logic pr, input logic sr, input logic rd,
                          input logic fl, input int rc, input int llc);
    exp_t e;
    mk(e, c, pr, sr, rd, fl, rc, llc);
    poll_q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic lose_and_relock(input int llc);
    int l, m;
    l = cyc;
    pll_lock = 1'b0;
    exp_chg(l + 3, 1, 1, 0, 0, 0, llc);
    exp_chg(l + 7, 0, 1, 0, 0, 0, llc);
    wait_until(l + 8);
    m = cyc;
    pll_lock = 1'b1;
    exp_chg(m + 11, 0, 0, 1, 0, 0, llc);
    wait_until(m + 12);
  endtask

  // change monitor: every output change must match the next queued expectation
  initial forever begin
    @(pll_rst or sys_rst or ready or fail or retry_count or lock_loss_count);
    #1;
    if (mon_en) begin
      if (chg_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_change: cyc=%0d pll_rst=%b sys_rst=%b ready=%b fail=%b retry=%0d loss=%0d, required no change",
                 cyc, pll_rst, sys_rst, ready, fail, retry_count, lock_loss_count);
      end else begin
        compare("change", chg_q.pop_front());
      end
    end
  end

  // poll monitor: steady-state snapshots at requested cycles
  initial forever begin
    @(negedge clock);
    #2;
    while (poll_q.size() > 0 && poll_q[0].c <= cyc) compare("poll", poll_q.pop_front());
  end

  initial begin
    #(8 * 40000);
    $display("FAIL watchdog: cyc=%0d, required finish before 40000 cycles", cyc);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, w, l, m, x, llc_e;
    reset    = 1'b1;
    pll_lock = 1'b0;

    // reset values, held across clock edges
    repeat (2) @(negedge clock);
    exp_poll(cyc, 1, 1, 0, 0, 0, 0);
    @(negedge clock);
    exp_poll(cyc, 1, 1, 0, 0, 0, 0);
    mon_en = 1'b1;
    @(negedge clock);

    // clean lock
    r = cyc;
    reset = 1'b0;
    exp_poll(r + 3, 1, 1, 0, 0, 0, 0);
    exp_chg(r + 4, 0, 1, 0, 0, 0, 0);
    w = r + 4;
    wait_until(w + 3);
    pll_lock = 1'b1;
    exp_chg(w + 3 + 11, 0, 0, 1, 0, 0, 0);
    wait_until(w + 3 + 12);

    // lock loss, single timeout, then lock on the timeout clock
    l = cyc;
    pll_lock = 1'b0;
    exp_chg(l + 3, 1, 1, 0, 0, 0, 1);
    exp_chg(l + 7, 0, 1, 0, 0, 0, 1);
    w = l + 7;
    exp_chg(w + 20, 1, 1, 0, 0, 1, 1);
    exp_chg(w + 24, 0, 1, 0, 0, 1, 1);
    w = w + 24;
    exp_poll(w + 20, 0, 1, 0, 0, 1, 1);
    wait_until(w + 17);
    pll_lock = 1'b1;
    exp_chg(w + 17 + 11, 0, 0, 1, 0, 0, 1);
    wait_until(w + 17 + 12);

    // unstable lock: high 5, low 1, high again
    l = cyc;
    pll_lock = 1'b0;
    exp_chg(l + 3, 1, 1, 0, 0, 0, 2);
    exp_chg(l + 7, 0, 1, 0, 0, 0, 2);
    w = l + 7;
    wait_until(w + 2);
    m = cyc;
    pll_lock = 1'b1;
    exp_poll(m + 11, 0, 1, 0, 0, 0, 2);
    exp_chg(m + 17, 0, 0, 1, 0, 0, 2);
    wait_until(m + 5);
    pll_lock = 1'b0;
    wait_until(m + 6);
    pll_lock = 1'b1;
    wait_until(m + 18);

    // async reset in the middle of STABLE
    l = cyc;
    pll_lock = 1'b0;
    exp_chg(l + 3, 1, 1, 0, 0, 0, 3);
    exp_chg(l + 7, 0, 1, 0, 0, 0, 3);
    wait_until(l + 8);
    m = cyc;
    pll_lock = 1'b1;
    wait_until(m + 6);
    exp_chg(m + 6, 1, 1, 0, 0, 0, 0);
    exp_poll(m + 6, 1, 1, 0, 0, 0, 0);
    #1 reset = 1'b1;
    pll_lock = 1'b0;
    repeat (2) @(negedge clock);
    r = cyc;
    reset = 1'b0;
    exp_chg(r + 4, 0, 1, 0, 0, 0, 0);

    // never lock: two timeouts to FAILED, late lock ignored, reset clears
    w = r + 4;
    exp_chg(w + 20, 1, 1, 0, 0, 1, 0);
    exp_chg(w + 24, 0, 1, 0, 0, 1, 0);
    exp_chg(w + 44, 0, 1, 0, 1, 2, 0);
    wait_until(w + 46);
    pll_lock = 1'b1;
    exp_poll(w + 70, 0, 1, 0, 1, 2, 0);
    wait_until(w + 72);
    x = cyc;
    exp_chg(x, 1, 1, 0, 0, 0, 0);
    exp_poll(x, 1, 1, 0, 0, 0, 0);
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    r = cyc;
    reset = 1'b0;
    exp_chg(r + 4, 0, 1, 0, 0, 0, 0);
    exp_chg(r + 13, 0, 0, 1, 0, 0, 0);
    wait_until(r + 14);

    // repeated lock loss, counter saturates at 255
    llc_e = 0;
    for (int i = 0; i < 300; i++) begin
      if (llc_e < 255) llc_e++;
      lose_and_relock(llc_e);
    end

    // async reset in the middle of PLL_RESET
    l = cyc;
    pll_lock = 1'b0;
    exp_chg(l + 3, 1, 1, 0, 0, 0, 255);
    wait_until(l + 5);
    exp_chg(l + 5, 1, 1, 0, 0, 0, 0);
    exp_poll(l + 5, 1, 1, 0, 0, 0, 0);
    #1 reset = 1'b1;
    pll_lock = 1'b1;
    repeat (2) @(negedge clock);
    r = cyc;
    reset = 1'b0;
    exp_chg(r + 4, 0, 1, 0, 0, 0, 0);
    exp_chg(r + 13, 0, 0, 1, 0, 0, 0);
    wait_until(r + 16);

    n_checks++;
    if (chg_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_changes: %0d expected changes never seen, required 0 (next at cyc %0d)",
               chg_q.size(), chg_q[0].c);
    end
    n_checks++;
    if (poll_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_polls: %0d snapshots not taken, required 0", poll_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
